// File: rtl/desition_param.sv
// Interval timer with capture register and a mode-selectable comparator.
// A capture strobe latches the live count and restarts the counter one cycle later.
module desition_param #(
  parameter int          WIDTH  = 20,
  parameter int unsigned MARGIN = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             timer,
  input  logic             register,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out_timer,
  output logic [WIDTH-1:0] out_reg,
  output logic             comp,
  output logic             valid,
  output logic             ovf
);

  typedef enum logic {EMPTY = 1'b0, ARMED = 1'b1} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
  localparam logic [WIDTH:0]   MARGIN_EXT = (WIDTH+1)'(MARGIN);

  state_t         state_r;
  logic           reg_d_r;
  logic [WIDTH:0] ref_margin_s;
  logic           cmp_s;

  // Counter, capture register, delayed strobe and reference-valid FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_timer <= '0;
      out_reg   <= '0;
      ovf       <= 1'b0;
      reg_d_r   <= 1'b0;
      state_r   <= EMPTY;
    end else if (clr) begin
      out_timer <= '0;
      out_reg   <= '0;
      ovf       <= 1'b0;
      reg_d_r   <= 1'b0;
      state_r   <= EMPTY;
    end else begin
      if (register) begin
        out_reg <= out_timer;
        reg_d_r <= 1'b1;
        state_r <= ARMED;
      end else begin
        reg_d_r <= 1'b0;
      end
      // The restart from the previous strobe beats any increment on this edge.
      if (reg_d_r) begin
        out_timer <= '0;
        ovf       <= 1'b0;
      end else if (timer) begin
        if (out_timer == CNT_MAX) begin
          ovf <= 1'b1;
        end else begin
          out_timer <= out_timer + CNT_ONE;
        end
      end
    end
  end

  assign valid = (state_r == ARMED);

  // Mode comparator; margin sum is one bit wider so it can never wrap.
  always_comb begin
    ref_margin_s = {1'b0, out_reg} + MARGIN_EXT;
    cmp_s        = 1'b0;
    case (mode)
      2'd0:    cmp_s = (out_timer == out_reg);
      2'd1:    cmp_s = (out_timer >= out_reg);
      2'd2:    cmp_s = ({1'b0, out_timer} >= ref_margin_s);
      2'd3:    cmp_s = (out_timer < out_reg);
      default: cmp_s = 1'b0;
    endcase
    if (valid) begin
      comp = cmp_s;
    end else begin
      comp = 1'b0;
    end
  end

endmodule

// File: tb/tb_desition_param.sv
// Directed bench for desition_param: three instances share stimulus
// (WIDTH=20/MARGIN=0, WIDTH=20/MARGIN=3, WIDTH=4/MARGIN=0).
module tb_desition_param;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        timer;
  logic        register;
  logic [1:0]  mode;

  logic [19:0] a_timer, a_reg, b_timer, b_reg;
  logic        a_comp, a_valid, a_ovf, b_comp, b_valid, b_ovf;
  logic [3:0]  s_timer, s_reg;
  logic        s_comp, s_valid, s_ovf;

  int checks;
  int fails;

  desition_param #(.WIDTH(20), .MARGIN(32'd0)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .timer(timer), .register(register), .mode(mode),
    .out_timer(a_timer), .out_reg(a_reg), .comp(a_comp), .valid(a_valid), .ovf(a_ovf));

  desition_param #(.WIDTH(20), .MARGIN(32'd3)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .timer(timer), .register(register), .mode(mode),
    .out_timer(b_timer), .out_reg(b_reg), .comp(b_comp), .valid(b_valid), .ovf(b_ovf));

  desition_param #(.WIDTH(4), .MARGIN(32'd0)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .timer(timer), .register(register), .mode(mode),
    .out_timer(s_timer), .out_reg(s_reg), .comp(s_comp), .valid(s_valid), .ovf(s_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; timer = 1'b0; register = 1'b0; mode = 2'd0;
    tick(2);
    checks++; if ({a_timer, a_reg, a_valid, a_ovf} !== 42'd0) begin
      fails++; $display("FAIL reset_state: got timer=%0d reg=%0d valid=%0b ovf=%0b, expected all 0", a_timer, a_reg, a_valid, a_ovf); end
    rst = 1'b0;
    timer = 1'b1;
    tick(3);
    register = 1'b1;
    tick(1);
    register = 1'b0;
    checks++; if (a_timer !== 20'd4 || a_reg !== 20'd3 || a_valid !== 1'b1) begin
      fails++; $display("FAIL pre_reset_capture: got timer=%0d reg=%0d valid=%0b, expected 4/3/1", a_timer, a_reg, a_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({a_timer, a_reg, a_valid, a_ovf} !== 42'd0) begin
      fails++; $display("FAIL async_reset: got timer=%0d reg=%0d valid=%0b ovf=%0b, expected all 0", a_timer, a_reg, a_valid, a_ovf); end
    for (int m = 0; m < 4; m++) begin
      mode = m[1:0];
      #1;
      checks++; if (a_comp !== 1'b0) begin
        fails++; $display("FAIL comp_invalid_mode%0d: got %0b expected 0", m, a_comp); end
    end
    timer = 1'b0;
    mode = 2'd0;
    tick(1);
    rst = 1'b0;
    tick(2);
    checks++; if (a_timer !== 20'd0 || a_valid !== 1'b0) begin
      fails++; $display("FAIL post_reset_idle: got timer=%0d valid=%0b, expected 0/0", a_timer, a_valid); end
  endtask

  task automatic test_capture_compare();
    timer = 1'b1;
    tick(10);
    register = 1'b1;
    tick(1);
    register = 1'b0;
    checks++; if (a_reg !== 20'd10 || a_valid !== 1'b1 || a_timer !== 20'd11) begin
      fails++; $display("FAIL capture: got reg=%0d valid=%0b timer=%0d, expected 10/1/11", a_reg, a_valid, a_timer); end
    tick(1);
    checks++; if (a_timer !== 20'd0) begin
      fails++; $display("FAIL restart: got timer=%0d expected 0", a_timer); end
    mode = 2'd3; #1;
    checks++; if (a_comp !== 1'b1) begin
      fails++; $display("FAIL mode3_count0: got %0b expected 1", a_comp); end
    tick(9);
    checks++; if (a_timer !== 20'd9 || a_comp !== 1'b1) begin
      fails++; $display("FAIL mode3_count9: got timer=%0d comp=%0b, expected 9/1", a_timer, a_comp); end
    mode = 2'd0; #1;
    checks++; if (a_comp !== 1'b0) begin
      fails++; $display("FAIL mode0_count9: got %0b expected 0", a_comp); end
    tick(1);
    checks++; if (a_timer !== 20'd10 || a_comp !== 1'b1) begin
      fails++; $display("FAIL mode0_count10: got timer=%0d comp=%0b, expected 10/1", a_timer, a_comp); end
    mode = 2'd3; #1;
    checks++; if (a_comp !== 1'b0) begin
      fails++; $display("FAIL mode3_count10: got %0b expected 0", a_comp); end
    mode = 2'd1; #1;
    checks++; if (a_comp !== 1'b1) begin
      fails++; $display("FAIL mode1_count10: got %0b expected 1", a_comp); end
    mode = 2'd2;
    tick(2);
    checks++; if (b_timer !== 20'd12 || b_reg !== 20'd10 || b_comp !== 1'b0) begin
      fails++; $display("FAIL margin_count12: got timer=%0d reg=%0d comp=%0b, expected 12/10/0", b_timer, b_reg, b_comp); end
    checks++; if (a_comp !== 1'b1) begin
      fails++; $display("FAIL margin0_count12: got %0b expected 1", a_comp); end
    tick(1);
    checks++; if (b_comp !== 1'b1) begin
      fails++; $display("FAIL margin_count13: got %0b expected 1", b_comp); end
    mode = 2'd0;
  endtask

  task automatic test_saturation();
    // Small instance sits at 13 here; restart it first.
    register = 1'b1;
    tick(1);
    register = 1'b0;
    tick(1);
    checks++; if (s_timer !== 4'd0 || s_ovf !== 1'b0) begin
      fails++; $display("FAIL sat_start: got timer=%0d ovf=%0b, expected 0/0", s_timer, s_ovf); end
    tick(15);
    checks++; if (s_timer !== 4'd15 || s_ovf !== 1'b0) begin
      fails++; $display("FAIL sat_reach15: got timer=%0d ovf=%0b, expected 15/0", s_timer, s_ovf); end
    tick(1);
    checks++; if (s_timer !== 4'd15 || s_ovf !== 1'b1) begin
      fails++; $display("FAIL sat_hold: got timer=%0d ovf=%0b, expected 15/1", s_timer, s_ovf); end
    tick(2);
    register = 1'b1;
    tick(1);
    register = 1'b0;
    checks++; if (s_reg !== 4'd15 || s_timer !== 4'd15 || s_ovf !== 1'b1) begin
      fails++; $display("FAIL sat_capture: got reg=%0d timer=%0d ovf=%0b, expected 15/15/1", s_reg, s_timer, s_ovf); end
    tick(1);
    checks++; if (s_timer !== 4'd0 || s_ovf !== 1'b0 || a_ovf !== 1'b0) begin
      fails++; $display("FAIL sat_restart: got timer=%0d ovf=%0b wide_ovf=%0b, expected 0/0/0", s_timer, s_ovf, a_ovf); end
  endtask

  task automatic test_back_to_back();
    tick(5);
    checks++; if (a_timer !== 20'd5) begin
      fails++; $display("FAIL b2b_count5: got %0d expected 5", a_timer); end
    register = 1'b1;
    tick(1);
    checks++; if (a_reg !== 20'd5 || a_timer !== 20'd6) begin
      fails++; $display("FAIL b2b_first: got reg=%0d timer=%0d, expected 5/6", a_reg, a_timer); end
    tick(1);
    register = 1'b0;
    checks++; if (a_reg !== 20'd6 || a_timer !== 20'd0) begin
      fails++; $display("FAIL b2b_second: got reg=%0d timer=%0d, expected 6/0", a_reg, a_timer); end
    tick(1);
    checks++; if (a_timer !== 20'd0 || a_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_restart2: got timer=%0d valid=%0b, expected 0/1", a_timer, a_valid); end
  endtask

  task automatic test_clear();
    tick(7);
    checks++; if (a_timer !== 20'd7) begin
      fails++; $display("FAIL clr_count7: got %0d expected 7", a_timer); end
    clr = 1'b1; register = 1'b1; mode = 2'd1;
    tick(1);
    clr = 1'b0; register = 1'b0; timer = 1'b0;
    checks++; if (a_reg !== 20'd0 || a_timer !== 20'd0 || a_valid !== 1'b0 || a_comp !== 1'b0) begin
      fails++; $display("FAIL clr_with_strobe: got reg=%0d timer=%0d valid=%0b comp=%0b, expected 0/0/0/0", a_reg, a_timer, a_valid, a_comp); end
    tick(1);
    checks++; if (a_valid !== 1'b0 || a_timer !== 20'd0) begin
      fails++; $display("FAIL clr_no_pending: got valid=%0b timer=%0d, expected 0/0", a_valid, a_timer); end
    register = 1'b1;
    tick(1);
    register = 1'b0;
    checks++; if (a_valid !== 1'b1 || a_reg !== 20'd0 || a_comp !== 1'b1) begin
      fails++; $display("FAIL clr_rearm: got valid=%0b reg=%0d comp=%0b, expected 1/0/1", a_valid, a_reg, a_comp); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_capture_compare();
    test_saturation();
    test_back_to_back();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
